// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage with PC register, IF/ID pipeline
//               register, branch redirect/flush and RUN/DONE/FAULT control.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_BYTES = 96
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    output logic [63:0] IFID_PC,
    output logic [31:0] IFID_Instruction,
    output logic        IFID_valid,
    output logic        done,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam logic [63:0] c_imem_limit = 64'(IMEM_BYTES);
    localparam logic [31:0] c_nop        = 32'h0000_0013;
    localparam logic [31:0] c_count_max  = 32'hFFFF_FFFF;

    localparam logic [1:0] c_st_run   = 2'd0;
    localparam logic [1:0] c_st_done  = 2'd1;
    localparam logic [1:0] c_st_fault = 2'd2;

    logic [63:0] r_pc;
    logic [63:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;
    logic [31:0] r_fetch_count;
    logic [1:0]  r_state;

    logic [63:0] w_pc_plus4;
    logic        w_target_aligned;
    logic        w_target_in_range;
    logic        w_last_fetch;
    logic [31:0] w_count_next;

    // Sequential PC increment wraps naturally at 2^64.
    assign w_pc_plus4        = r_pc + 64'd4;
    assign w_target_aligned  = (branch_target[1:0] == 2'b00);
    assign w_target_in_range = (branch_target < c_imem_limit);
    assign w_last_fetch      = (w_pc_plus4 >= c_imem_limit);
    assign w_count_next      = (r_fetch_count == c_count_max) ? r_fetch_count
                                                              : r_fetch_count + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_ifid_pc     <= 64'd0;
            r_ifid_instr  <= c_nop;
            r_ifid_valid  <= 1'b0;
            r_fetch_count <= 32'd0;
            r_state       <= c_st_run;
        end else if (r_state == c_st_fault) begin
            r_ifid_instr <= c_nop;
            r_ifid_valid <= 1'b0;
        end else if (branch_taken) begin
            // Redirect wins over stall; the wrong-path fetch becomes a bubble.
            r_pc         <= branch_target;
            r_ifid_instr <= c_nop;
            r_ifid_valid <= 1'b0;
            if (!w_target_aligned) begin
                r_state <= c_st_fault;
            end else if (w_target_in_range) begin
                r_state <= c_st_run;
            end else begin
                r_state <= c_st_done;
            end
        end else if (stall) begin
            r_pc <= r_pc;
        end else if (r_state == c_st_done) begin
            r_ifid_instr <= c_nop;
            r_ifid_valid <= 1'b0;
        end else begin
            r_ifid_pc     <= r_pc;
            r_ifid_instr  <= Instruction;
            r_ifid_valid  <= 1'b1;
            r_fetch_count <= w_count_next;
            r_pc          <= w_pc_plus4;
            if (w_last_fetch) begin
                r_state <= c_st_done;
            end
        end
    end

    assign Inst_Address     = r_pc;
    assign IFID_PC          = r_ifid_pc;
    assign IFID_Instruction = r_ifid_instr;
    assign IFID_valid       = r_ifid_valid;
    assign fetch_count      = r_fetch_count;
    assign done             = (r_state == c_st_done);
    assign fault            = (r_state == c_st_fault);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed and randomized bench for fetch_stage with a
//               behavioural fetch model and a small instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam int          c_imem_bytes = 96;
    localparam logic [63:0] c_reset_pc   = 64'h0;
    localparam logic [31:0] c_nop        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = 64'd0;
    logic [63:0] Inst_Address;
    logic [31:0] Instruction;
    logic [63:0] IFID_PC;
    logic [31:0] IFID_Instruction;
    logic        IFID_valid;
    logic        done;
    logic        fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:23];
    logic [31:0] oob_word;

    // Behavioural model of the architectural state.
    logic [63:0] m_pc;
    logic [63:0] m_ifid_pc;
    logic [31:0] m_ifid_instr;
    logic        m_valid;
    logic [31:0] m_count;
    bit          m_halted;
    bit          m_faulted;

    fetch_stage #(
        .RESET_PC   (c_reset_pc),
        .IMEM_BYTES (c_imem_bytes)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .Inst_Address     (Inst_Address),
        .Instruction      (Instruction),
        .IFID_PC          (IFID_PC),
        .IFID_Instruction (IFID_Instruction),
        .IFID_valid       (IFID_valid),
        .done             (done),
        .fault            (fault),
        .fetch_count      (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [63:0] a);
        if (a < 64'(c_imem_bytes)) return mem[a[6:2]];
        return oob_word;
    endfunction

    assign Instruction = mem_read(Inst_Address);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input bit rst, input bit st, input bit br, input logic [63:0] tgt);
        logic [31:0] word;
        logic [63:0] nxt;
        word = mem_read(m_pc);
        reset = rst;
        stall = st;
        branch_taken = br;
        branch_target = tgt;
        if (rst) begin
            m_pc = c_reset_pc;
            m_ifid_pc = 64'd0;
            m_ifid_instr = c_nop;
            m_valid = 1'b0;
            m_count = 32'd0;
            m_halted = 1'b0;
            m_faulted = 1'b0;
        end else if (m_faulted) begin
            m_ifid_instr = c_nop;
            m_valid = 1'b0;
        end else if (br) begin
            m_pc = tgt;
            m_ifid_instr = c_nop;
            m_valid = 1'b0;
            m_faulted = (tgt % 4) != 0;
            m_halted = !m_faulted && (tgt >= 64'(c_imem_bytes));
        end else if (st) begin
            // everything holds
        end else if (m_halted) begin
            m_ifid_instr = c_nop;
            m_valid = 1'b0;
        end else begin
            m_ifid_pc = m_pc;
            m_ifid_instr = word;
            m_valid = 1'b1;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            nxt = m_pc + 64'd4;
            if (nxt >= 64'(c_imem_bytes)) m_halted = 1'b1;
            m_pc = nxt;
        end
        @(posedge clk);
        #1;
        chk("inst_address", Inst_Address, m_pc);
        chk("ifid_pc", IFID_PC, m_ifid_pc);
        chk("ifid_instruction", IFID_Instruction, m_ifid_instr);
        chk("ifid_valid", IFID_valid, m_valid);
        chk("fetch_count", fetch_count, m_count);
        chk("done", done, m_halted);
        chk("fault", fault, m_faulted);
    endtask

    initial begin
        for (int i = 0; i < 24; i++) mem[i] = $urandom;
        oob_word = $urandom;
        mem[0] = 32'h0010_0313;
        mem[1] = 32'h0040_0393;
        mem[2] = 32'h0050_0413;

        step(1, 0, 0, 64'd0);
        step(1, 0, 0, 64'd0);
        chk("rst_instr", IFID_Instruction, c_nop);
        chk("rst_valid", IFID_valid, 1'b0);

        // Three free-running fetches from address 0.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 64'd0);
            chk("free_ifid_pc", IFID_PC, 64'(4 * i));
            chk("free_addr", Inst_Address, 64'(4 * i + 4));
        end
        chk("free_count", fetch_count, 32'd3);
        chk("free_instr2", IFID_Instruction, 32'h0050_0413);

        // Stall two cycles with PC=8.
        step(1, 0, 0, 64'd0);
        step(0, 0, 0, 64'd0);
        step(0, 0, 0, 64'd0);
        step(0, 1, 0, 64'd0);
        step(0, 1, 0, 64'd0);
        chk("stall_addr", Inst_Address, 64'd8);
        chk("stall_ifid_pc", IFID_PC, 64'd4);
        chk("stall_instr", IFID_Instruction, 32'h0040_0393);
        chk("stall_count", fetch_count, 32'd2);
        step(0, 0, 0, 64'd0);
        chk("resume_ifid_pc", IFID_PC, 64'd8);

        // Branch beats stall.
        step(0, 1, 1, 64'h20);
        chk("br_valid", IFID_valid, 1'b0);
        chk("br_instr", IFID_Instruction, c_nop);
        chk("br_addr", Inst_Address, 64'h20);
        step(0, 0, 0, 64'd0);
        chk("br_ifid_pc", IFID_PC, 64'h20);
        chk("br_valid2", IFID_valid, 1'b1);

        // Run off the end of memory.
        step(0, 0, 1, 64'd88);
        step(0, 0, 0, 64'd0);
        step(0, 0, 0, 64'd0);
        chk("end_ifid_pc", IFID_PC, 64'd92);
        chk("end_valid", IFID_valid, 1'b1);
        chk("end_done", done, 1'b1);
        step(0, 0, 0, 64'd0);
        chk("done_valid", IFID_valid, 1'b0);
        chk("done_addr", Inst_Address, 64'd96);
        step(0, 0, 1, 64'd0);
        chk("restart_done", done, 1'b0);
        step(0, 0, 0, 64'd0);
        chk("restart_valid", IFID_valid, 1'b1);

        // Misaligned branch locks into FAULT until reset.
        step(0, 0, 1, 64'h22);
        chk("fault_set", fault, 1'b1);
        step(0, 0, 1, 64'h0);
        chk("fault_addr", Inst_Address, 64'h22);
        chk("fault_valid", IFID_valid, 1'b0);
        step(1, 0, 0, 64'd0);
        chk("fault_clear", fault, 1'b0);
        chk("fault_rst_pc", Inst_Address, 64'd0);

        // Reset during stall.
        step(0, 0, 1, 64'h40);
        step(1, 1, 0, 64'd0);
        chk("rst_stall_pc", Inst_Address, 64'd0);
        chk("rst_stall_count", fetch_count, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            bit          r_rst, r_st, r_br;
            logic [63:0] tgt;
            int          kind;
            r_rst = ($urandom % 64) == 0;
            r_st  = ($urandom % 4) == 0;
            r_br  = ($urandom % 6) == 0;
            kind  = int'($urandom % 8);
            if (kind < 5)       tgt = 64'(($urandom % 24) * 4);
            else if (kind == 5) tgt = 64'(($urandom % 96) | 1);
            else if (kind == 6) tgt = {$urandom, $urandom} & ~64'd3 | 64'h100;
            else                tgt = 64'd96;
            if (($urandom % 32) == 0) mem[$urandom % 24] = $urandom;
            step(r_rst, r_st, r_br, tgt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
